// File: rtl/mux_pkg.sv
// Shared constants for the streaming multiplexer family.
// Mode encodings and parameter limits used by mux_n_stream.
package mux_pkg;

    localparam logic MODE_ARB  = 1'b0;
    localparam logic MODE_MAN  = 1'b1;

    localparam int   N_MAX     = 16;
    localparam int   BURST_MAX = 255;

endpackage

// File: rtl/mux_n_stream_rr_pick.sv
// rr_pick: combinational first-set search from a start pointer.
// Returns a one-hot grant, its index, and whether any bit was found.
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    int c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(start) + k) % N;
            if (!any && req[c]) begin
                grant[c] = 1'b1;
                idx      = SW'(c);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// N-channel valid/ready stream mux with registered output and burst arbiter.
// Optional even-parity output enabled by MUX_N_STREAM_PARITY_EN.
module mux_n_stream
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int BURST = 1,
    localparam int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
`ifdef MUX_N_STREAM_PARITY_EN
    output logic           out_par,
`endif
    input  logic           out_ready
);

    localparam logic [7:0] BURST_C = 8'(BURST);

    logic [SW-1:0] ptr;
    logic [SW-1:0] last;
    logic [7:0]    cnt;
    logic          lock;
    logic          mode_q;

    logic          load_en;
    logic          mode_chg;
    logic          lock_eff;
    logic          hold;
    logic          xfer;
    logic [N-1:0]  pick_grant;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  sel_data;
    logic [7:0]    cnt_nxt;
    logic [SW-1:0] ptr_nxt;

    rr_pick #(.N(N)) u_pick (
        .req   (in_valid),
        .start (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign load_en  = !out_valid || out_ready;
    assign mode_chg = mode != mode_q;
    // A stale lock must not survive a return from manual mode.
    assign lock_eff = lock && !mode_chg;
    assign hold     = (mode == MODE_ARB) && lock_eff &&
                      in_valid[last] && (cnt < BURST_C);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        unique case (1'b1)
            mode == MODE_MAN: begin
                if (int'(sel) < N) begin
                    grant[sel] = in_valid[sel];
                    grant_idx  = sel;
                end
            end
            hold: begin
                grant[last] = 1'b1;
                grant_idx   = last;
            end
            default: begin
                grant     = pick_grant;
                grant_idx = pick_idx;
            end
        endcase
    end

    assign in_ready = grant & {N{load_en && rst_n}};
    assign xfer     = |in_ready;
    assign sel_data = in_data[grant_idx*W +: W];

    assign cnt_nxt = (lock_eff && grant_idx == last) ? cnt + 8'd1 : 8'd1;
    assign ptr_nxt = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_N_STREAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (xfer) begin
            out_par <= ^sel_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            last   <= '0;
            cnt    <= '0;
            lock   <= 1'b0;
            mode_q <= MODE_ARB;
        end else begin
            mode_q <= mode;
            if (xfer) begin
                last <= grant_idx;
            end
            if (mode == MODE_ARB && xfer) begin
                cnt  <= cnt_nxt;
                lock <= cnt_nxt < BURST_C;
                ptr  <= ptr_nxt;
            end else if (mode_chg) begin
                cnt  <= '0;
                lock <= 1'b0;
            end else if (mode == MODE_ARB && !in_valid[last]) begin
                lock <= 1'b0;
            end
        end
    end

endmodule
